// File: rtl/seven_seg_capture.sv
// seven_seg_capture: receive side of the multiplexed seven-segment bus.
// Waits for each {anode, segment} pattern to be stable for STABLE_CYCLES
// samples, then decodes the pattern back to a hex digit. Digits are
// assembled into a NUM_DIGITS frame.
// Optional feature: define SEVSEG_CAP_ERRCNT_EN to build the saturating
// 8-bit error counter on err_count. When it is undefined, err_count is tied to 0.
module seven_seg_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   an_in,
    input  logic [6:0]              seg_in,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    frame_valid,
    output logic                    frame_pulse,
    output logic [7:0]              err_count
);

    typedef enum logic [1:0] {IDLE, COLLECT, FRAME} state_t;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STABLE_CYCLES);

    // Segment lines are active-low, bit6=a .. bit0=g. Result is {invalid, value}.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b0000001: r = 5'h00;
            7'b1001111: r = 5'h01;
            7'b0010010: r = 5'h02;
            7'b0000110: r = 5'h03;
            7'b1001100: r = 5'h04;
            7'b0100100: r = 5'h05;
            7'b0100000: r = 5'h06;
            7'b0001111: r = 5'h07;
            7'b0000000: r = 5'h08;
            7'b0000100: r = 5'h09;
            7'b0001000: r = 5'h0A;
            7'b1100000: r = 5'h0B;
            7'b0110001: r = 5'h0C;
            7'b1000010: r = 5'h0D;
            7'b0110000: r = 5'h0E;
            7'b0111000: r = 5'h0F;
            default:    r = 5'h10;
        endcase
        return r;
    endfunction

    // Stage 0: sample register and stability tracking
    logic [NUM_DIGITS-1:0] an_p0;
    logic [6:0]            seg_p0;
    logic [CNT_W-1:0]      cnt_p0;
    logic                  captured_p0;

    logic [NUM_DIGITS-1:0] sel_p0;
    logic                  one_low_p0;
    logic                  win_p0;
    logic                  cap_p0;
    logic [4:0]            dec_p0;

    // Any change on the bus restarts the stability window. A window is
    // consumed once whether or not it produced a capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_p0       <= '1;
            seg_p0      <= '1;
            cnt_p0      <= '0;
            captured_p0 <= 1'b0;
        end else if ({an_in, seg_in} != {an_p0, seg_p0}) begin
            an_p0       <= an_in;
            seg_p0      <= seg_in;
            cnt_p0      <= CNT_W'(1);
            captured_p0 <= 1'b0;
        end else begin
            if (cnt_p0 != CNT_FULL)
                cnt_p0 <= cnt_p0 + CNT_W'(1);
            if (win_p0)
                captured_p0 <= 1'b1;
        end
    end

    assign sel_p0     = ~an_p0;
    assign one_low_p0 = ($countones(sel_p0) == 1);
    assign win_p0     = (cnt_p0 == CNT_FULL) && !captured_p0;
    assign cap_p0     = win_p0 && one_low_p0;
    assign dec_p0     = seg_decode(seg_p0);

    // Stage 1: digit store, seen mask and frame FSM
    state_t                  state_p1, state_n;
    logic [NUM_DIGITS-1:0]   seen_p1, seen_n;
    logic [4*NUM_DIGITS-1:0] digits_p1, digits_n;
    logic [NUM_DIGITS-1:0]   derr_p1, derr_n;
    logic                    fvalid_p1, fvalid_n;

    // Next-state: clear wins; the FRAME cycle restarts the mask and a capture
    // landing in the same cycle goes into the fresh mask.
    always_comb begin
        state_n  = state_p1;
        seen_n   = seen_p1;
        digits_n = digits_p1;
        derr_n   = derr_p1;
        fvalid_n = fvalid_p1;
        if (clear) begin
            state_n  = IDLE;
            seen_n   = '0;
            digits_n = '0;
            derr_n   = '0;
            fvalid_n = 1'b0;
        end else begin
            if (state_p1 == FRAME) begin
                fvalid_n = 1'b1;
                seen_n   = '0;
                state_n  = COLLECT;
            end
            if (cap_p0) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (sel_p0[i]) begin
                        digits_n[4*i +: 4] = dec_p0[3:0];
                        derr_n[i]          = dec_p0[4];
                    end
                end
                seen_n  = seen_n | sel_p0;
                state_n = (&seen_n) ? FRAME : COLLECT;
            end
        end
    end

    // State and capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1  <= IDLE;
            seen_p1   <= '0;
            digits_p1 <= '0;
            derr_p1   <= '0;
            fvalid_p1 <= 1'b0;
        end else begin
            state_p1  <= state_n;
            seen_p1   <= seen_n;
            digits_p1 <= digits_n;
            derr_p1   <= derr_n;
            fvalid_p1 <= fvalid_n;
        end
    end

    assign digits_out  = digits_p1;
    assign digit_err   = derr_p1;
    assign frame_valid = fvalid_p1;
    assign frame_pulse = (state_p1 == FRAME);

`ifdef SEVSEG_CAP_ERRCNT_EN
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic       multi_low_p0;
    logic [7:0] ec_p1, ec_n;

    assign multi_low_p0 = ($countones(sel_p0) > 1);

    // Count invalid captures and stable windows with several anodes low.
    always_comb begin
        ec_n = ec_p1;
        if (clear)
            ec_n = 8'd0;
        else if ((cap_p0 && dec_p0[4]) || (win_p0 && multi_low_p0))
            ec_n = sat_inc8(ec_p1);
    end

    // Error counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ec_p1 <= 8'd0;
        else
            ec_p1 <= ec_n;
    end

    assign err_count = ec_p1;
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_seven_seg_capture.sv
// tb_seven_seg_capture: directed scenarios for seven_seg_capture with
// hand-computed expected digits, flags and error counts.
module tb_seven_seg_capture;

    logic        clk;
    logic        rst_n;
    logic [3:0]  an_in;
    logic [6:0]  seg_in;
    logic        clear;
    logic [15:0] digits_out;
    logic [3:0]  digit_err;
    logic        frame_valid;
    logic        frame_pulse;
    logic [7:0]  err_count;

    int tests_run = 0;
    int fails     = 0;
    int pulses    = 0;

`ifdef SEVSEG_CAP_ERRCNT_EN
    localparam bit ERRCNT_ON = 1'b1;
`else
    localparam bit ERRCNT_ON = 1'b0;
`endif

    localparam logic [3:0] BLANK_AN  = 4'b1111;
    localparam logic [6:0] BLANK_SEG = 7'b1111111;

    seven_seg_capture #(
        .NUM_DIGITS   (4),
        .STABLE_CYCLES(4),
        .CNT_W        (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .an_in      (an_in),
        .seg_in     (seg_in),
        .clear      (clear),
        .digits_out (digits_out),
        .digit_err  (digit_err),
        .frame_valid(frame_valid),
        .frame_pulse(frame_pulse),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (frame_pulse === 1'b1) pulses++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0: return 7'b0000001;   1: return 7'b1001111;
            2: return 7'b0010010;   3: return 7'b0000110;
            4: return 7'b1001100;   5: return 7'b0100100;
            6: return 7'b0100000;   7: return 7'b0001111;
            8: return 7'b0000000;   9: return 7'b0000100;
            10: return 7'b0001000;  11: return 7'b1100000;
            12: return 7'b0110001;  13: return 7'b1000010;
            14: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    // Drive a pattern for n rising edges; called and returns at a falling edge.
    task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
        an_in  = an;
        seg_in = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        clear  = 1'b0;
        an_in  = BLANK_AN;
        seg_in = BLANK_SEG;
        repeat (3) @(negedge clk);
        tests_run++;
        if (digits_out !== 16'h0000) begin fails++; $display("FAIL reset_digits: got %h want 0000", digits_out); end
        tests_run++;
        if ({digit_err, frame_valid, frame_pulse} !== 6'b0) begin fails++; $display("FAIL reset_flags: got err=%b fv=%b fp=%b want 0", digit_err, frame_valid, frame_pulse); end
        tests_run++;
        if (err_count !== 8'd0) begin fails++; $display("FAIL reset_errcnt: got %0d want 0", err_count); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        hold(4'b1110, seg_of(3), 4);
        tests_run++;
        if (digits_out !== 16'h0000) begin fails++; $display("FAIL single_early: got %h want 0000 before edge 4", digits_out); end
        hold(BLANK_AN, BLANK_SEG, 1);
        tests_run++;
        if (digits_out !== 16'h0003) begin fails++; $display("FAIL single_digit: got %h want 0003", digits_out); end
        tests_run++;
        if (digit_err !== 4'b0000) begin fails++; $display("FAIL single_err: got %b want 0000", digit_err); end
        tests_run++;
        if (frame_pulse !== 1'b0 || frame_valid !== 1'b0 || pulses != 0) begin fails++; $display("FAIL single_noframe: fp=%b fv=%b pulses=%0d want 0/0/0", frame_pulse, frame_valid, pulses); end
    endtask

    task automatic test_scan();
        int p0;
        p0 = pulses;
        hold(4'b1110, seg_of(1), 6);
        hold(4'b1101, seg_of(2), 6);
        hold(4'b1011, seg_of(3), 6);
        hold(4'b0111, seg_of(10), 6);
        tests_run++;
        if (digits_out !== 16'hA321) begin fails++; $display("FAIL scan_digits: got %h want A321", digits_out); end
        tests_run++;
        if (frame_valid !== 1'b1) begin fails++; $display("FAIL scan_valid: got %b want 1", frame_valid); end
        hold(BLANK_AN, BLANK_SEG, 3);
        tests_run++;
        if (pulses - p0 != 1) begin fails++; $display("FAIL scan_pulses: got %0d want 1", pulses - p0); end
        tests_run++;
        if (frame_pulse !== 1'b0) begin fails++; $display("FAIL scan_pulse_len: got %b want 0", frame_pulse); end
    endtask

    task automatic test_short();
        hold(4'b1110, seg_of(8), 3);
        hold(BLANK_AN, BLANK_SEG, 6);
        tests_run++;
        if (digits_out !== 16'hA321) begin fails++; $display("FAIL short_nocap: got %h want A321", digits_out); end
        tests_run++;
        if (digit_err !== 4'b0000 || err_count !== 8'd0) begin fails++; $display("FAIL blank_noerr: err=%b cnt=%0d want 0000/0", digit_err, err_count); end
    endtask

    task automatic test_invalid();
        hold(4'b1011, 7'b1111111, 6);
        tests_run++;
        if (digits_out !== 16'hA021) begin fails++; $display("FAIL invalid_value: got %h want A021", digits_out); end
        tests_run++;
        if (digit_err !== 4'b0100) begin fails++; $display("FAIL invalid_err: got %b want 0100", digit_err); end
        tests_run++;
        if (err_count !== (ERRCNT_ON ? 8'd1 : 8'd0)) begin fails++; $display("FAIL invalid_errcnt: got %0d want %0d", err_count, ERRCNT_ON ? 1 : 0); end
    endtask

    task automatic test_multi();
        hold(4'b1100, seg_of(8), 10);
        tests_run++;
        if (digits_out !== 16'hA021) begin fails++; $display("FAIL multi_nocap: got %h want A021", digits_out); end
        tests_run++;
        if (err_count !== (ERRCNT_ON ? 8'd2 : 8'd0)) begin fails++; $display("FAIL multi_errcnt: got %0d want %0d", err_count, ERRCNT_ON ? 2 : 0); end
        hold(BLANK_AN, BLANK_SEG, 6);
        tests_run++;
        if (digits_out !== 16'hA021 || digit_err !== 4'b0100) begin fails++; $display("FAIL blank_after_multi: got %h/%b want A021/0100", digits_out, digit_err); end
        tests_run++;
        if (err_count !== (ERRCNT_ON ? 8'd2 : 8'd0)) begin fails++; $display("FAIL blank_errcnt: got %0d want %0d", err_count, ERRCNT_ON ? 2 : 0); end
    endtask

    task automatic test_clear();
        int p0;
        p0 = pulses;
        hold(4'b1110, seg_of(5), 6);
        hold(4'b1101, seg_of(7), 6);
        tests_run++;
        if (digits_out !== 16'hA075 || frame_valid !== 1'b1) begin fails++; $display("FAIL preclear: got %h fv=%b want A075 fv=1", digits_out, frame_valid); end
        an_in  = BLANK_AN;
        seg_in = BLANK_SEG;
        clear  = 1'b1;
        @(negedge clk);
        clear  = 1'b0;
        tests_run++;
        if (digits_out !== 16'h0000 || digit_err !== 4'b0000) begin fails++; $display("FAIL clear_digits: got %h/%b want 0000/0000", digits_out, digit_err); end
        tests_run++;
        if (frame_valid !== 1'b0 || frame_pulse !== 1'b0 || err_count !== 8'd0) begin fails++; $display("FAIL clear_flags: fv=%b fp=%b cnt=%0d want 0/0/0", frame_valid, frame_pulse, err_count); end
        hold(4'b0111, seg_of(15), 6);
        hold(4'b1110, seg_of(4), 6);
        hold(4'b1101, seg_of(9), 6);
        tests_run++;
        if (pulses != p0 || frame_valid !== 1'b0) begin fails++; $display("FAIL clear_partial: pulses=%0d fv=%b want %0d/0", pulses, frame_valid, p0); end
        hold(4'b1011, seg_of(12), 6);
        hold(BLANK_AN, BLANK_SEG, 2);
        tests_run++;
        if (pulses - p0 != 1) begin fails++; $display("FAIL clear_rescan_pulses: got %0d want 1", pulses - p0); end
        tests_run++;
        if (digits_out !== 16'hFC94 || frame_valid !== 1'b1) begin fails++; $display("FAIL clear_rescan: got %h fv=%b want FC94 fv=1", digits_out, frame_valid); end
    endtask

    task automatic test_reset_mid();
        int p0;
        p0 = pulses;
        hold(4'b1110, seg_of(8), 6);
        hold(4'b1101, seg_of(0), 6);
        hold(4'b1011, seg_of(6), 2);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (digits_out !== 16'h0000 || digit_err !== 4'b0000) begin fails++; $display("FAIL async_rst_digits: got %h/%b want 0000/0000", digits_out, digit_err); end
        tests_run++;
        if (frame_valid !== 1'b0 || frame_pulse !== 1'b0 || err_count !== 8'd0) begin fails++; $display("FAIL async_rst_flags: fv=%b fp=%b cnt=%0d want 0/0/0", frame_valid, frame_pulse, err_count); end
        @(negedge clk);
        rst_n = 1'b1;
        hold(4'b1110, seg_of(1), 5);
        tests_run++;
        if (digits_out !== 16'h0001 || frame_valid !== 1'b0 || pulses != p0) begin fails++; $display("FAIL after_rst: got %h fv=%b pulses=%0d want 0001/0/%0d", digits_out, frame_valid, pulses, p0); end
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = pulses;
        hold(4'b1110, seg_of(0), 4);
        hold(4'b1101, seg_of(1), 4);
        hold(4'b1011, seg_of(2), 4);
        hold(4'b0111, seg_of(3), 4);
        hold(4'b1110, seg_of(14), 4);
        hold(4'b1101, seg_of(13), 4);
        hold(4'b1011, seg_of(12), 4);
        hold(4'b0111, seg_of(11), 4);
        hold(BLANK_AN, BLANK_SEG, 2);
        tests_run++;
        if (pulses - p0 != 2) begin fails++; $display("FAIL b2b_pulses: got %0d want 2", pulses - p0); end
        tests_run++;
        if (digits_out !== 16'hBCDE || frame_valid !== 1'b1 || digit_err !== 4'b0000) begin fails++; $display("FAIL b2b_digits: got %h fv=%b err=%b want BCDE/1/0000", digits_out, frame_valid, digit_err); end
    endtask

    task automatic test_decode_all();
        for (int v = 0; v < 16; v++) begin
            hold(4'b1110, seg_of(v), 5);
            tests_run++;
            if (digits_out[3:0] !== 4'(v) || digit_err[0] !== 1'b0) begin fails++; $display("FAIL decode_%0d: got %h err=%b want %h err=0", v, digits_out[3:0], digit_err[0], v); end
        end
        tests_run++;
        if (err_count !== 8'd0) begin fails++; $display("FAIL decode_errcnt: got %0d want 0", err_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_scan();
        test_short();
        test_invalid();
        test_multi();
        test_clear();
        test_reset_mid();
        test_back_to_back();
        test_decode_all();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
